// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared states, constants and mm:ss helpers for the alarm clock
package alarm_clock_pkg;

    localparam int SEC_PER_MIN = 60;
    localparam int MAX_COUNT   = 3599;

    // Encodings double as the edit_sel display code.
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_SET_SEC = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_ALM_MIN = 3'd5,
        ST_ALM_SEC = 3'd6
    } mode_state_t;

    function automatic logic [5:0] step_mod60(input logic [5:0] v, input logic up, input logic down);
        logic [5:0] r;
        r = v;
        if (up && !down) begin
            r = (v >= 6'd59) ? 6'd0 : v + 6'd1;
        end else if (down && !up) begin
            r = (v == 6'd0) ? 6'd59 : v - 6'd1;
        end
        return r;
    endfunction

    // m*60 + s as m*64 - m*4 + s; m <= 59 keeps every term inside 12 bits.
    function automatic logic [11:0] mmss_to_sec(input logic [5:0] m, input logic [5:0] s);
        return {m, 6'b0} - {4'b0, m, 2'b0} + {6'b0, s};
    endfunction

endpackage

// File: rtl/mode_controller_if.sv
// rtl/mode_controller_if.sv - button, counter and alarm signals between mode_controller and its neighbours
interface mode_controller_if;

    logic        tick_1s;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic        btn_pause;
    logic [11:0] count;

    logic        ENABLE;
    logic        time_flows;
    logic [11:0] SET_TIME;
    logic [11:0] alarm_time;
    logic        alarm_armed;
    logic        ringing;
    logic [2:0]  edit_sel;

    modport master (
        input  tick_1s, btn_mode, btn_up, btn_down, btn_pause, count,
        output ENABLE, time_flows, SET_TIME, alarm_time, alarm_armed, ringing, edit_sel
    );

    modport slave (
        output tick_1s, btn_mode, btn_up, btn_down, btn_pause, count,
        input  ENABLE, time_flows, SET_TIME, alarm_time, alarm_armed, ringing, edit_sel
    );

endinterface

// File: rtl/sec_to_mmss.sv
// rtl/sec_to_mmss.sv - iterative seconds to mm:ss converter, one subtraction of 60 per cycle
module sec_to_mmss #(
    parameter int MAX_COUNT = alarm_clock_pkg::MAX_COUNT
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        start,
    input  logic [11:0] value,
    output logic        busy,
    output logic        done,
    output logic [5:0]  mm,
    output logic [5:0]  ss
);

    localparam logic [11:0] CLAMP    = 12'(MAX_COUNT);
    localparam logic [11:0] MIN_STEP = 12'(alarm_clock_pkg::SEC_PER_MIN);

    logic [11:0] residual;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            residual <= '0;
            mm       <= '0;
            ss       <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                residual <= (value > CLAMP) ? CLAMP : value;
                mm       <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                if (residual >= MIN_STEP) begin
                    residual <= residual - MIN_STEP;
                    mm       <= mm + 6'd1;
                end else begin
                    ss   <= residual[5:0];
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mode_controller.sv
// rtl/mode_controller.sv - run/set/alarm-edit sequencer driving the 1 s counter and the alarm
module mode_controller import alarm_clock_pkg::*; #(
    parameter int RING_SECS = 30,
    parameter int MAX_COUNT = alarm_clock_pkg::MAX_COUNT
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    mode_controller_if.master bus
);

    mode_state_t state, state_nxt;

    logic [5:0] min_r, sec_r, amin_r, asec_r;
    logic [5:0] ring_cnt;
    logic       matched;

    logic       conv_start, conv_busy, conv_done;
    logic [5:0] conv_mm, conv_ss;

    logic any_btn, silence, bm, bp, bu, bd;
    logic in_alm, alarm_start;

    // While ringing, any press only silences; otherwise mode > pause > up/down.
    assign any_btn = bus.btn_mode | bus.btn_up | bus.btn_down | bus.btn_pause;
    assign silence = bus.ringing & any_btn;
    assign bm      = bus.btn_mode  & ~bus.ringing;
    assign bp      = bus.btn_pause & ~bus.ringing & ~bus.btn_mode;
    assign bu      = bus.btn_up    & ~bus.ringing & ~bus.btn_mode & ~bus.btn_pause;
    assign bd      = bus.btn_down  & ~bus.ringing & ~bus.btn_mode & ~bus.btn_pause;

    assign in_alm     = (state == ST_ALM_MIN) || (state == ST_ALM_SEC);
    assign conv_start = (state == ST_RUN) && bm;

    assign alarm_start = bus.ENABLE && bus.alarm_armed && bus.tick_1s &&
                         (bus.count == bus.alarm_time) && !bus.ringing && !matched;

    sec_to_mmss #(.MAX_COUNT(MAX_COUNT)) u_conv (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .start   (conv_start),
        .value   (bus.count),
        .busy    (conv_busy),
        .done    (conv_done),
        .mm      (conv_mm),
        .ss      (conv_ss)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (bm) state_nxt = ST_LOAD;
            // An idle converter without a result would strand LOAD; fall back to RUN.
            ST_LOAD:    if (conv_done) state_nxt = ST_SET_MIN;
                        else if (!conv_busy) state_nxt = ST_RUN;
            ST_SET_MIN: if (bm) state_nxt = ST_SET_SEC;
            ST_SET_SEC: if (bm) state_nxt = ST_COMMIT;
            ST_COMMIT:  if (bus.tick_1s) state_nxt = ST_ALM_MIN;
            ST_ALM_MIN: if (bm) state_nxt = ST_ALM_SEC;
            ST_ALM_SEC: if (bm) state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= ST_RUN;
            bus.edit_sel    <= ST_RUN;
            bus.ENABLE      <= 1'b1;
            bus.time_flows  <= 1'b1;
            bus.alarm_armed <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.edit_sel <= state_nxt;
            bus.ENABLE   <= !((state_nxt == ST_SET_MIN) || (state_nxt == ST_SET_SEC) ||
                              (state_nxt == ST_COMMIT));
            if ((state == ST_RUN) && bp) bus.time_flows  <= ~bus.time_flows;
            if (in_alm && bp)            bus.alarm_armed <= ~bus.alarm_armed;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            min_r          <= '0;
            sec_r          <= '0;
            amin_r         <= '0;
            asec_r         <= '0;
            bus.SET_TIME   <= '0;
            bus.alarm_time <= '0;
        end else begin
            bus.SET_TIME   <= mmss_to_sec(min_r, sec_r);
            bus.alarm_time <= mmss_to_sec(amin_r, asec_r);
            case (state)
                ST_LOAD: begin
                    if (conv_done) begin
                        min_r <= conv_mm;
                        sec_r <= conv_ss;
                    end
                end
                ST_SET_MIN: min_r  <= step_mod60(min_r, bu, bd);
                ST_SET_SEC: sec_r  <= step_mod60(sec_r, bu, bd);
                ST_ALM_MIN: amin_r <= step_mod60(amin_r, bu, bd);
                ST_ALM_SEC: asec_r <= step_mod60(asec_r, bu, bd);
                default: ;
            endcase
        end
    end

    // matched blocks retrigger until a tick shows the count has moved off the alarm time.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            bus.ringing <= 1'b0;
            ring_cnt    <= '0;
            matched     <= 1'b0;
        end else begin
            if (silence) begin
                bus.ringing <= 1'b0;
                ring_cnt    <= '0;
            end else if (bus.ringing && bus.tick_1s) begin
                if (ring_cnt <= 6'd1) begin
                    bus.ringing <= 1'b0;
                    ring_cnt    <= '0;
                end else begin
                    ring_cnt <= ring_cnt - 6'd1;
                end
            end else if (alarm_start) begin
                bus.ringing <= 1'b1;
                ring_cnt    <= 6'(RING_SECS);
            end

            if (alarm_start) begin
                matched <= 1'b1;
            end else if (bus.tick_1s && (bus.count != bus.alarm_time)) begin
                matched <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mode_controller.sv
// tb/tb_mode_controller.sv - directed, table and randomized checks of mode_controller
module tb_mode_controller;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLOCK = ~CLOCK;

    mode_controller_if bus();

    mode_controller #(.RING_SECS(30), .MAX_COUNT(3599)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain arithmetic on minutes/seconds and behavioural state numbers.
    int m_st, m_tf, m_arm, m_ring, m_rcnt, m_match;
    int m_mn, m_sc, m_amn, m_asc, m_set, m_alm, m_en, m_lw, m_cv;

    typedef struct {
        int m, u, d, p, t, c;
        int e_sel, e_flows, e_en;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tf = 1; m_arm = 0; m_ring = 0; m_rcnt = 0; m_match = 0;
        m_mn = 0; m_sc = 0; m_amn = 0; m_asc = 0; m_set = 0; m_alm = 0;
        m_en = 1; m_lw = 0; m_cv = 0;
    endtask

    function automatic int wrap60(input int v, input int up, input int dn);
        if (up && !dn) return (v + 1) % 60;
        if (dn && !up) return (v + 59) % 60;
        return v;
    endfunction

    task automatic model_step(input int m, input int u, input int d, input int p, input int t, input int c);
        int n_st, n_tf, n_arm, n_ring, n_rcnt, n_match, n_mn, n_sc, n_amn, n_asc, n_lw, n_cv;
        int sil, em, ep, eu, ed, start;
        sil = m_ring && (m || u || d || p);
        em  = m && !sil;
        ep  = p && !sil && !m;
        eu  = u && !sil && !m && !p;
        ed  = d && !sil && !m && !p;
        n_st = m_st; n_tf = m_tf; n_arm = m_arm; n_ring = m_ring; n_rcnt = m_rcnt;
        n_match = m_match; n_mn = m_mn; n_sc = m_sc; n_amn = m_amn; n_asc = m_asc;
        n_lw = m_lw; n_cv = m_cv;
        case (m_st)
            0: if (em) begin
                   n_st = 1;
                   n_cv = (c > 3599) ? 3599 : c;
                   n_lw = n_cv / 60 + 2;
               end else if (ep) n_tf = !m_tf;
            1: begin
                   n_lw = m_lw - 1;
                   if (n_lw == 0) begin
                       n_st = 2; n_mn = m_cv / 60; n_sc = m_cv % 60;
                   end
               end
            2: if (em) n_st = 3; else n_mn = wrap60(m_mn, eu, ed);
            3: if (em) n_st = 4; else n_sc = wrap60(m_sc, eu, ed);
            4: if (t) n_st = 5;
            5: if (em) n_st = 6; else if (ep) n_arm = !m_arm; else n_amn = wrap60(m_amn, eu, ed);
            6: if (em) n_st = 0; else if (ep) n_arm = !m_arm; else n_asc = wrap60(m_asc, eu, ed);
            default: n_st = 0;
        endcase
        start = m_en && m_arm && t && (c == m_alm) && !m_ring && !m_match;
        if (sil) begin
            n_ring = 0; n_rcnt = 0;
        end else if (m_ring && t) begin
            n_rcnt = m_rcnt - 1;
            if (n_rcnt <= 0) begin n_ring = 0; n_rcnt = 0; end
        end else if (start) begin
            n_ring = 1; n_rcnt = 30;
        end
        if (start) n_match = 1;
        else if (t && c != m_alm) n_match = 0;
        m_set = m_mn * 60 + m_sc;
        m_alm = m_amn * 60 + m_asc;
        m_st = n_st; m_tf = n_tf; m_arm = n_arm; m_ring = n_ring; m_rcnt = n_rcnt;
        m_match = n_match; m_mn = n_mn; m_sc = n_sc; m_amn = n_amn; m_asc = n_asc;
        m_lw = n_lw; m_cv = n_cv;
        m_en = !(m_st == 2 || m_st == 3 || m_st == 4);
    endtask

    task automatic compare_model();
        chk("model edit_sel", int'(bus.edit_sel), m_st);
        chk("model ENABLE", int'(bus.ENABLE), m_en);
        chk("model time_flows", int'(bus.time_flows), m_tf);
        chk("model SET_TIME", int'(bus.SET_TIME), m_set);
        chk("model alarm_time", int'(bus.alarm_time), m_alm);
        chk("model alarm_armed", int'(bus.alarm_armed), m_arm);
        chk("model ringing", int'(bus.ringing), m_ring);
    endtask

    task automatic cyc(input int m, input int u, input int d, input int p, input int t, input int c);
        bus.btn_mode  = 1'(m);
        bus.btn_up    = 1'(u);
        bus.btn_down  = 1'(d);
        bus.btn_pause = 1'(p);
        bus.tick_1s   = 1'(t);
        bus.count     = 12'(c);
        model_step(m, u, d, p, t, c);
        @(posedge CLOCK);
        #1;
        compare_model();
    endtask

    task automatic idle(input int n, input int c);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, c);
    endtask

    task automatic do_reset();
        bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_pause = 0;
        bus.tick_1s = 0; bus.count = '0;
        RESET_N = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        compare_model();
    endtask

    initial begin
        int seen_done;
        int c, sel;

        tbl[0] = '{0, 0, 0, 1, 0, 0,    0, 0, 1};
        tbl[1] = '{0, 0, 0, 0, 1, 100,  0, 0, 1};
        tbl[2] = '{0, 0, 0, 1, 0, 0,    0, 1, 1};
        tbl[3] = '{1, 0, 0, 1, 0, 3599, 1, 1, 1};

        do_reset();
        chk("reset ENABLE", int'(bus.ENABLE), 1);
        chk("reset time_flows", int'(bus.time_flows), 1);
        chk("reset SET_TIME", int'(bus.SET_TIME), 0);
        chk("reset ringing", int'(bus.ringing), 0);
        chk("reset edit_sel", int'(bus.edit_sel), 0);
        chk("reset alarm_time", int'(bus.alarm_time), 0);

        for (int i = 0; i < 4; i++) begin
            cyc(tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].p, tbl[i].t, tbl[i].c);
            chk($sformatf("vec%0d edit_sel", i), int'(bus.edit_sel), tbl[i].e_sel);
            chk($sformatf("vec%0d time_flows", i), int'(bus.time_flows), tbl[i].e_flows);
            chk($sformatf("vec%0d ENABLE", i), int'(bus.ENABLE), tbl[i].e_en);
        end

        // 3599 takes 61 cycles in LOAD before SET_MIN.
        idle(60, 3599);
        chk("load still LOAD", int'(bus.edit_sel), 1);
        idle(1, 3599);
        chk("load -> SET_MIN", int'(bus.edit_sel), 2);
        chk("SET_MIN ENABLE", int'(bus.ENABLE), 0);
        idle(1, 3599);
        chk("converted 59:59", int'(bus.SET_TIME), 3599);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1, 0);
        chk("min wrap up", int'(bus.SET_TIME), 59);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 0);
        idle(1, 0);
        chk("min 12", int'(bus.SET_TIME), 779);
        cyc(0, 1, 1, 0, 0, 0);
        idle(1, 0);
        chk("up+down no change", int'(bus.SET_TIME), 779);
        cyc(1, 1, 0, 0, 0, 0);
        chk("mode+up -> SET_SEC", int'(bus.edit_sel), 3);
        idle(1, 0);
        chk("mode+up field kept", int'(bus.SET_TIME), 779);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1, 0);
        chk("sec wrap up", int'(bus.SET_TIME), 720);
        cyc(0, 0, 1, 0, 0, 0);
        idle(1, 0);
        chk("sec wrap down", int'(bus.SET_TIME), 779);
        for (int i = 0; i < 35; i++) cyc(0, 1, 0, 0, 0, 0);
        idle(1, 0);
        chk("SET_TIME 12:34", int'(bus.SET_TIME), 754);

        cyc(1, 0, 0, 0, 0, 0);
        chk("COMMIT entered", int'(bus.edit_sel), 4);
        idle(5, 0);
        chk("COMMIT holds", int'(bus.edit_sel), 4);
        chk("COMMIT ENABLE", int'(bus.ENABLE), 0);
        cyc(0, 0, 0, 0, 1, 754);
        chk("tick -> ALM_MIN", int'(bus.edit_sel), 5);
        chk("ALM_MIN ENABLE", int'(bus.ENABLE), 1);

        cyc(1, 0, 0, 0, 0, 754);
        chk("ALM_SEC", int'(bus.edit_sel), 6);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 754);
        idle(2, 754);
        chk("alarm_time 00:05", int'(bus.alarm_time), 5);
        cyc(0, 0, 0, 1, 0, 754);
        chk("armed", int'(bus.alarm_armed), 1);
        cyc(1, 0, 0, 0, 0, 754);
        chk("back to RUN", int'(bus.edit_sel), 0);

        idle(2, 5);
        chk("no ring without tick", int'(bus.ringing), 0);
        cyc(0, 0, 0, 0, 1, 5);
        chk("ring starts", int'(bus.ringing), 1);
        for (int i = 0; i < 29; i++) cyc(0, 0, 0, 0, 1, 100 + i);
        chk("ring after 29 ticks", int'(bus.ringing), 1);
        cyc(0, 0, 0, 0, 1, 200);
        chk("ring ends at 30", int'(bus.ringing), 0);

        cyc(0, 0, 0, 0, 1, 5);
        chk("ring again", int'(bus.ringing), 1);
        cyc(0, 0, 0, 0, 1, 6);
        cyc(0, 0, 0, 0, 1, 7);
        cyc(0, 1, 0, 0, 0, 7);
        chk("silenced", int'(bus.ringing), 0);
        idle(2, 7);
        chk("silence SET_TIME kept", int'(bus.SET_TIME), 754);
        chk("silence alarm_time kept", int'(bus.alarm_time), 5);
        chk("silence state RUN", int'(bus.edit_sel), 0);
        chk("silence flows kept", int'(bus.time_flows), 1);

        // Reset while the converter is mid-way through a long conversion.
        cyc(1, 0, 0, 0, 0, 3000);
        idle(10, 3000);
        chk("pre-reset busy", int'(dut.u_conv.busy), 1);
        RESET_N = 1'b0;
        #2;
        chk("reset busy cleared", int'(dut.u_conv.busy), 0);
        chk("reset done cleared", int'(dut.u_conv.done), 0);
        chk("reset mid-LOAD RUN", int'(bus.edit_sel), 0);
        model_reset();
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 0, 0, 0, 3000);
            if (dut.u_conv.done) seen_done = 1;
        end
        chk("no stale done", seen_done, 0);
        chk("stays RUN", int'(bus.edit_sel), 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 3);
            if (sel < 2)       c = m_alm;
            else if (sel == 2) c = $urandom_range(0, 3599);
            else               c = $urandom_range(0, 4095);
            cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 4) == 0), c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_controller.md
# mode_controller

Mode/edit sequencer for the alarm clock's seconds counter (0..3599, mm:ss within one hour). It decodes debounced button pulses into a run/set/alarm-edit state machine and drives the counter's `ENABLE`, `time_flows` and `SET_TIME` inputs. It also holds the alarm time and raises a timed alarm. It runs on the fast system clock and sits between the button conditioners and the 1 s counter.

## Interface
- `RING_SECS`, default 30: alarm duration in 1 s ticks (1..63).
- `MAX_COUNT`, default 3599: largest counter value.
- `CLOCK`, in, 1: system clock.
- `RESET_N`, in, 1: asynchronous, active-low reset.
- `tick_1s`, in, 1: one-cycle pulse in the `CLOCK` domain, asserted the cycle after each `CLOCK_1s` rising edge.
- `btn_mode`, `btn_up`, `btn_down`, `btn_pause`, in, 1 each: debounced one-cycle press pulses.
- `count`, in, 12: current counter value; stable whenever `tick_1s`=1.
- `ENABLE`, out, 1: counter enable; 0 forces the counter to load `SET_TIME`.
- `time_flows`, out, 1: counter advance permit.
- `SET_TIME`, out, 12: edited time, min*60+sec.
- `alarm_time`, out, 12: alarm value, amin*60+asec.
- `alarm_armed`, out, 1: alarm armed.
- `ringing`, out, 1: alarm active.
- `edit_sel`, out, 3: current state code, for display blink.

## Operation
- States: RUN, LOAD, SET_MIN, SET_SEC, COMMIT, ALM_MIN, ALM_SEC.
- RUN:
  - `btn_pause` toggles `time_flows`.
  - `btn_mode` snapshots `count` into the converter and moves to LOAD.
- LOAD: wait for converter `done`, latch min/sec, then go to SET_MIN. All buttons are ignored.
- SET_MIN / SET_SEC:
  - `btn_up`/`btn_down` add or subtract 1 on the selected field, modulo 60 (59 up → 0, 0 down → 59).
  - `btn_mode`: SET_MIN → SET_SEC → COMMIT.
- COMMIT: keep `ENABLE`=0 until a `tick_1s` is seen, which guarantees the counter has sampled `SET_TIME`. Then go to ALM_MIN.
- ALM_MIN / ALM_SEC:
  - Up/down edit amin/asec, modulo 60.
  - `btn_pause` toggles `alarm_armed`.
  - `btn_mode`: ALM_MIN → ALM_SEC → RUN.
- `ENABLE` = 0 in SET_MIN, SET_SEC and COMMIT; 1 in all other states.
- Button priority within one cycle: mode > pause > up/down. `btn_up` and `btn_down` together produce no change.
- Alarm start: in any state with `ENABLE`=1, when `alarm_armed`, `tick_1s`, `count`==`alarm_time` and not `ringing` all hold, set `ringing`=1 and ring_cnt = `RING_SECS`.
- Alarm run: ring_cnt decrements on each `tick_1s`, and `ringing` clears when it reaches 0.
- Alarm silence: any button pulse while ringing clears `ringing`. That pulse is consumed and has no other effect.
- The alarm does not retrigger until `count` next equals `alarm_time`.
- Converter (`sec_to_mmss`):
  - On `start` it clamps the input to `MAX_COUNT`.
  - It then repeatedly subtracts 60 from the residual, incrementing mm each cycle, until residual < 60.
  - Result: ss = residual; `done` pulses for 1 cycle.
- Reset values:
  - state=RUN, `ENABLE`=1, `time_flows`=1.
  - `SET_TIME`=0, `alarm_time`=0, min/sec/amin/asec=0.
  - `alarm_armed`=0, `ringing`=0, ring_cnt=0.
  - `edit_sel`=RUN code.
- Reset mid-LOAD aborts the converter; its `busy`/`done` clear.

## Timing
- All outputs are registered.
- `SET_TIME`/`alarm_time` update the cycle after the field register changes, i.e. 2 cycles after the button pulse.
- State changes 1 cycle after the qualifying input.
- Converter latency: floor(v/60)+2 cycles from `start` to `done`; 61 cycles maximum (v=3599).
- `ringing` rises 1 cycle after the matching `tick_1s`.

## Structure
- Package `alarm_clock_pkg`:
  - State enum and state codes (also used for `edit_sel`).
  - `SEC_PER_MIN`=60, `MAX_COUNT`=3599.
  - Helper function for mod-60 increment/decrement.
- Sub-module `sec_to_mmss`:
  - Ports: `CLOCK`, `RESET_N`, `start`, `value[11:0]`, `busy`, `done`, `mm[5:0]`, `ss[5:0]`.
- The min*60+sec composition is a constant shift-add, e.g. (m<<6)-(m<<2)+s.

## Test plan
- **Reset/run:** assert `RESET_N`=0, release, idle → `ENABLE`=1, `time_flows`=1, `SET_TIME`=0, `ringing`=0. Then `btn_pause` → `time_flows`=0.
- **Load and convert:** `count`=3599, `btn_mode` → LOAD for 61 cycles, then SET_MIN with min=59, sec=59. `btn_up` → min=0, `SET_TIME`=59. `ENABLE`=0.
- **Edit wrap:** in SET_SEC at sec=0, `btn_down` → sec=59. Set 12:34 → `SET_TIME`=754. `btn_mode` → COMMIT holds `ENABLE`=0 until `tick_1s`, then ALM_MIN with `ENABLE`=1.
- **Alarm:** set alarm 00:05, arm, return to RUN. Drive ticks with `count`=5 → `ringing`=1 for 30 ticks, then 0. Repeat with `btn_up` at tick 3 → `ringing` clears, min/sec unchanged.
- **Simultaneous/priority:** `btn_up`+`btn_down` in the same cycle → no change. `btn_mode`+`btn_up` → state advances, field unchanged.
- **Reset mid-LOAD:** reset pulse during conversion → state RUN, converter `busy`=0, no stale `done`.
